// File: rtl/bs_ctrl.sv
// Frame controller that sequences the bitstream packer, LZ77 engine and adler32 unit.
// It keeps per-frame token and word counts, queues up to three requests and aborts stalled frames.
module bs_ctrl #(
    parameter int TOK_WD = 16,
    parameter int TO_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              bs_start_o,
    output logic              lz_start_o,
    input  logic              lz_val_i,
    input  logic              lz_lst_i,
    input  logic              adler32_done_i,
    input  logic              bs_val_i,
    input  logic              bs_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [TOK_WD-1:0] tok_cnt_o,
    output logic [TOK_WD-1:0] word_cnt_o,
    output logic [1:0]        pend_o
);
    localparam int              WD_W    = $clog2(TO_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WAIT_ADL,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        armCnt_q, armCnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              adlerSeen_q, adlerSeen_d;
    logic [TOK_WD-1:0] tokCnt_q, tokCnt_d;
    logic [TOK_WD-1:0] wordCnt_q, wordCnt_d;
    logic [1:0]        pend_q, pend_d;
    logic              bsStart_q, bsStart_d;
    logic              lzStart_q, lzStart_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wdActive, activity, timeout, popReq, pushReq;

    assign busy_o   = (state_q != IDLE);
    assign wdActive = (state_q == RUN) || (state_q == WAIT_ADL) || (state_q == WAIT_DONE);
    assign activity = lz_val_i || adler32_done_i || bs_val_i;
    assign timeout  = wdActive && !activity && (wdog_q == WD_LAST);
    assign popReq   = (state_q == IDLE) && (pend_q != 2'd0);
    assign pushReq  = start_i && (busy_o || (pend_q != 2'd0));

    always_comb begin
        state_d     = state_q;
        armCnt_d    = armCnt_q;
        wdog_d      = wdog_q;
        adlerSeen_d = adlerSeen_q;
        tokCnt_d    = tokCnt_q;
        wordCnt_d   = wordCnt_q;
        pend_d      = pend_q;
        bsStart_d   = 1'b0;
        lzStart_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if ((state_q != IDLE) && bs_val_i && (wordCnt_q != '1)) begin
            wordCnt_d = wordCnt_q + 1'b1;
        end
        if (wdActive) begin
            wdog_d = activity ? '0 : wdog_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i || (pend_q != 2'd0)) begin
                    state_d     = ARM;
                    armCnt_d    = '0;
                    tokCnt_d    = '0;
                    wordCnt_d   = '0;
                    wdog_d      = '0;
                    adlerSeen_d = 1'b0;
                    bsStart_d   = 1'b1;
                end
            end
            ARM: begin
                // The packer needs two header cycles before the LZ77 engine may emit tokens.
                if (lz_val_i) begin
                    err_d = 1'b1;
                end
                if (adler32_done_i) begin
                    adlerSeen_d = 1'b1;
                end
                if (armCnt_q == 2'd1) begin
                    lzStart_d = 1'b1;
                end
                if (armCnt_q == 2'd2) begin
                    state_d = RUN;
                end else begin
                    armCnt_d = armCnt_q + 2'd1;
                end
            end
            RUN: begin
                if (adler32_done_i) begin
                    adlerSeen_d = 1'b1;
                end
                if (lz_val_i) begin
                    if (tokCnt_q != '1) begin
                        tokCnt_d = tokCnt_q + 1'b1;
                    end
                    if (lz_lst_i) begin
                        state_d = (adlerSeen_q || adler32_done_i) ? WAIT_DONE : WAIT_ADL;
                    end
                end
            end
            WAIT_ADL: begin
                if (lz_val_i) begin
                    err_d = 1'b1;
                end
                if (adler32_done_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (lz_val_i) begin
                    err_d = 1'b1;
                end
                if (bs_done_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completing frame wins over a watchdog expiry in the same cycle.
        if (timeout && !((state_q == WAIT_DONE) && bs_done_i)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        if (pushReq && !popReq) begin
            if (pend_q == 2'd3) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (popReq && !pushReq) begin
            pend_d = pend_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            armCnt_q    <= '0;
            wdog_q      <= '0;
            adlerSeen_q <= 1'b0;
            tokCnt_q    <= '0;
            wordCnt_q   <= '0;
            pend_q      <= '0;
            bsStart_q   <= 1'b0;
            lzStart_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armCnt_q    <= armCnt_d;
            wdog_q      <= wdog_d;
            adlerSeen_q <= adlerSeen_d;
            tokCnt_q    <= tokCnt_d;
            wordCnt_q   <= wordCnt_d;
            pend_q      <= pend_d;
            bsStart_q   <= bsStart_d;
            lzStart_q   <= lzStart_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bs_start_o = bsStart_q;
    assign lz_start_o = lzStart_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign tok_cnt_o  = tokCnt_q;
    assign word_cnt_o = wordCnt_q;
    assign pend_o     = pend_q;
endmodule

// File: doc/bs_ctrl.md
BS_CTRL -- requirements
Module: bs_ctrl

Interface
REQ-001 SHALL have parameter TOK_WD, default 16, width of the token and word counters.
REQ-002 SHALL have parameter TO_MAX, default 1023, watchdog limit in idle-progress cycles.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  in  1  host frame request, single-cycle pulse.
REQ-006 SHALL have port bs_start_o  out  1  start pulse to the bitstream packer.
REQ-007 SHALL have port lz_start_o  out  1  start pulse to the LZ77 engine.
REQ-008 SHALL have port lz_val_i  in  1  LZ77 token valid.
REQ-009 SHALL have port lz_lst_i  in  1  last-token marker; meaningful only with lz_val_i.
REQ-010 SHALL have port adler32_done_i  in  1  adler32 result ready, pulse.
REQ-011 SHALL have port bs_val_i  in  1  packer 32-bit output word valid.
REQ-012 SHALL have port bs_done_i  in  1  packer final-word pulse.
REQ-013 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-014 SHALL have port done_o  out  1  frame-complete pulse.
REQ-015 SHALL have port err_o  out  1  error pulse: watchdog expiry or protocol violation.
REQ-016 SHALL have port tok_cnt_o  out  TOK_WD  tokens accepted in the current or last frame.
REQ-017 SHALL have port word_cnt_o  out  TOK_WD  packer words in the current or last frame.
REQ-018 SHALL have port pend_o  out  2  queued frame requests, 0..3.

Function
REQ-019 SHALL implement FSM states IDLE, ARM, RUN, WAIT_ADL, WAIT_DONE.
REQ-020 IDLE SHALL go to ARM on the next cycle when start_i=1 or pend_o>0.
REQ-021 If pend_o>0 when leaving IDLE for ARM, pend_o SHALL decrement.
REQ-022 ARM SHALL last exactly 3 cycles, timed by an internal 2-bit counter.
REQ-023 In ARM, bs_start_o SHALL be high in ARM cycle 0 only.
REQ-024 In ARM, lz_start_o SHALL be high in ARM cycle 2 only, so the packer has passed its 2 header cycles before the first token.
REQ-025 At the end of ARM cycle 2 the FSM SHALL go to RUN.
REQ-026 Entering ARM SHALL clear tok_cnt_o, word_cnt_o, the watchdog counter and the adler-seen flag.
REQ-027 lz_val_i=1 during ARM SHALL pulse err_o; the token SHALL not be counted and the FSM SHALL continue.
REQ-028 In RUN, each lz_val_i=1 SHALL increment tok_cnt_o, saturating at all-ones.
REQ-029 In RUN, lz_val_i=1 with lz_lst_i=1 SHALL go to WAIT_DONE if adler-seen=1, else to WAIT_ADL.
REQ-030 adler32_done_i in ARM or RUN SHALL set adler-seen.
REQ-031 In WAIT_ADL, adler32_done_i SHALL go to WAIT_DONE.
REQ-032 lz_val_i=1 in WAIT_ADL or WAIT_DONE SHALL pulse err_o and SHALL be ignored.
REQ-033 In WAIT_DONE, bs_done_i SHALL pulse done_o for one cycle, coincident with the cycle after bs_done_i is sampled.
REQ-034 After bs_done_i in WAIT_DONE, the FSM SHALL go to IDLE; ARM then follows per REQ-020.
REQ-035 word_cnt_o SHALL increment on each bs_val_i=1 from ARM through WAIT_DONE inclusive, saturating; the bs_done_i-cycle word counts.
REQ-036 tok_cnt_o and word_cnt_o SHALL hold their values in IDLE.
REQ-037 The watchdog SHALL count cycles in RUN, WAIT_ADL and WAIT_DONE.
REQ-038 The watchdog SHALL reset to 0 on any lz_val_i, adler32_done_i or bs_val_i.
REQ-039 When the watchdog reaches TO_MAX, err_o SHALL pulse and the FSM SHALL go to IDLE; pend_o SHALL be kept.
REQ-040 start_i while busy_o=1 or while pend_o>0 SHALL increment pend_o, saturating at 3; requests at 3 SHALL be dropped with an err_o pulse.
REQ-041 start_i together with a pending decrement SHALL leave pend_o unchanged.
REQ-042 All outputs SHALL be registered, except busy_o, which is decoded from the state register.

Reset
REQ-043 rst=1 SHALL asynchronously force IDLE, all counters 0, adler-seen 0 and every output 0.
REQ-044 Reset mid-frame SHALL discard the frame; no done_o or err_o SHALL follow reset release.
REQ-045 The first start_i after reset release SHALL be serviced normally.

Verification
REQ-046 Nominal frame: start_i at T0 -> bs_start_o at T1, lz_start_o at T3; feed 5 tokens, the last with lz_lst_i; adler32_done_i 2 cycles later; 7 bs_val_i; bs_done_i -> done_o one cycle later, tok_cnt_o=5, word_cnt_o=7.
REQ-047 Early adler: adler32_done_i during RUN -> lz_lst_i goes directly to WAIT_DONE; WAIT_ADL is never entered.
REQ-048 Queue: 4 start_i during one busy frame -> pend_o=3, one err_o; 3 further frames run back-to-back; pend_o ends at 0.
REQ-049 Watchdog with TO_MAX=8: stop all inputs in RUN -> err_o after 8 silent cycles; busy_o falls and tok_cnt_o is held.
REQ-050 Protocol: lz_val_i in ARM cycle 1 -> err_o; tok_cnt_o stays 0.
REQ-051 Reset during WAIT_DONE -> all outputs 0; a subsequent bs_done_i gives no done_o.
